// File: rtl/midi_receiver.sv
// midi_receiver: 31250-baud 8N1 UART plus MIDI note-on/note-off parser; MIDI_CHANNEL_FILTER_EN restricts events to CHANNEL
module midi_receiver #(
    parameter int CLK_HZ  = 100000000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       event_strobe,
    output logic       frame_error
);
    localparam int BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(BIT);
    localparam logic [CW-1:0] BIT_END = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BIT / 2 - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] STOP = 2'd3;
`ifdef MIDI_CHANNEL_FILTER_EN
    localparam logic FILTER = 1'b1;
`else
    localparam logic FILTER = 1'b0;
`endif

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_done;
    logic [7:0]    status;
    logic          idx;
    logic [6:0]    d1;
    logic          chan_ok, last;

    assign chan_ok = !FILTER || (status[3:0] == 4'(CHANNEL));
    assign last = idx || (status[6:5] == 2'b10);

    // two-flop synchronizer plus previous value for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // UART framing: mid-bit sampling, glitch rejection on the start bit, stop-bit check
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_done   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_done   <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: if (rx_prev && !rx_sync) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == HALF_END) begin
                    state   <= rx_sync ? IDLE : DATA;
                    cnt     <= '0;
                    bit_idx <= '0;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == BIT_END) begin
                    cnt     <= '0;
                    shift   <= {rx_sync, shift[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                default: if (cnt == BIT_END) begin
                    state       <= IDLE;
                    byte_done   <= rx_sync;
                    frame_error <= !rx_sync;
                end else cnt <= cnt + 1'b1;
            endcase
        end
    end

    // message parser: running status, data indexing, note-on/off output
    always_ff @(posedge clk) begin
        if (reset) begin
            status       <= '0;
            idx          <= 1'b0;
            d1           <= '0;
            note         <= '0;
            velocity     <= '0;
            event_strobe <= 1'b0;
        end else begin
            event_strobe <= 1'b0;
            if (frame_error) begin
                status <= '0;
                idx    <= 1'b0;
            end else if (byte_done) begin
                if (shift[7:4] == 4'hF) begin
                    if (!shift[3]) begin
                        status <= '0;
                        idx    <= 1'b0;
                    end
                end else if (shift[7]) begin
                    status <= shift;
                    idx    <= 1'b0;
                end else if (status[7]) begin
                    if (!last) begin
                        d1  <= shift[6:0];
                        idx <= 1'b1;
                    end else begin
                        idx <= 1'b0;
                        if (chan_ok && status[7:5] == 3'b100) begin
                            note         <= d1;
                            velocity     <= status[4] ? shift[6:0] : 7'd0;
                            event_strobe <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
